// File: rtl/reservation_station.sv
// Reservation station: buffers issued ALU/branch ops, snoops the two result
// buses for missing operands and dispatches the lowest-index ready entry.
module reservation_station #(
    parameter int RS_SIZE = 16,
    parameter int ROB_LOG = 4,
    parameter int OP_LOG  = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rdy,
    input  logic               clear,
    input  logic               issue_valid,
    input  logic [OP_LOG-1:0]  issue_op,
    input  logic [31:0]        issue_Vj,
    input  logic [31:0]        issue_Vk,
    input  logic               issue_Rj,
    input  logic               issue_Rk,
    input  logic [ROB_LOG-1:0] issue_Qj,
    input  logic [ROB_LOG-1:0] issue_Qk,
    input  logic [31:0]        issue_imm,
    input  logic [31:0]        issue_pc,
    input  logic [ROB_LOG-1:0] issue_RobId,
    input  logic               cdb_alu_valid,
    input  logic [ROB_LOG-1:0] cdb_alu_RobId,
    input  logic [31:0]        cdb_alu_value,
    input  logic               cdb_lsb_valid,
    input  logic [ROB_LOG-1:0] cdb_lsb_RobId,
    input  logic [31:0]        cdb_lsb_value,
    output logic               rs_full,
    output logic               alu_valid,
    output logic [OP_LOG-1:0]  alu_op,
    output logic [31:0]        alu_Vj,
    output logic [31:0]        alu_Vk,
    output logic [31:0]        alu_imm,
    output logic [31:0]        alu_pc,
    output logic [ROB_LOG-1:0] alu_RobId
);
    localparam int unsigned N     = RS_SIZE;
    localparam int unsigned IDX_W = $clog2(RS_SIZE);
    localparam int unsigned CNT_W = IDX_W + 1;

    logic [N-1:0]       busy, rj, rk;
    logic [OP_LOG-1:0]  op  [N];
    logic [31:0]        vj  [N];
    logic [31:0]        vk  [N];
    logic [31:0]        imm [N];
    logic [31:0]        pc  [N];
    logic [ROB_LOG-1:0] qj  [N];
    logic [ROB_LOG-1:0] qk  [N];
    logic [ROB_LOG-1:0] rob [N];

    logic [N-1:0]       wake_rj, wake_rk;
    logic [31:0]        wake_vj [N];
    logic [31:0]        wake_vk [N];
    logic               new_rj, new_rk;
    logic [31:0]        new_vj, new_vk;
    logic               free_found, sel_found;
    logic [IDX_W-1:0]   free_idx, sel_idx;
    logic [CNT_W-1:0]   count;

    // Returns {ready, value}; the ALU bus wins when both carry the same tag.
    function automatic logic [32:0] snoop(
        input logic               r,
        input logic [ROB_LOG-1:0] q,
        input logic [31:0]        v,
        input logic               a_valid,
        input logic [ROB_LOG-1:0] a_id,
        input logic [31:0]        a_val,
        input logic               l_valid,
        input logic [ROB_LOG-1:0] l_id,
        input logic [31:0]        l_val
    );
        logic [32:0] res;
        res = {r, v};
        if (!r) begin
            if (a_valid && a_id == q)      res = {1'b1, a_val};
            else if (l_valid && l_id == q) res = {1'b1, l_val};
        end
        return res;
    endfunction

    always_comb begin
        {new_rj, new_vj} = snoop(issue_Rj, issue_Qj, issue_Vj,
                                 cdb_alu_valid, cdb_alu_RobId, cdb_alu_value,
                                 cdb_lsb_valid, cdb_lsb_RobId, cdb_lsb_value);
        {new_rk, new_vk} = snoop(issue_Rk, issue_Qk, issue_Vk,
                                 cdb_alu_valid, cdb_alu_RobId, cdb_alu_value,
                                 cdb_lsb_valid, cdb_lsb_RobId, cdb_lsb_value);
        for (int unsigned i = 0; i < N; i++) begin
            {wake_rj[i], wake_vj[i]} = snoop(rj[i], qj[i], vj[i],
                                 cdb_alu_valid, cdb_alu_RobId, cdb_alu_value,
                                 cdb_lsb_valid, cdb_lsb_RobId, cdb_lsb_value);
            {wake_rk[i], wake_vk[i]} = snoop(rk[i], qk[i], vk[i],
                                 cdb_alu_valid, cdb_alu_RobId, cdb_alu_value,
                                 cdb_lsb_valid, cdb_lsb_RobId, cdb_lsb_value);
        end
    end

    // Allocation and select both look at registered state only, so an entry
    // freed by dispatch cannot be reallocated on the same edge.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        sel_found  = 1'b0;
        sel_idx    = '0;
        count      = '0;
        for (int unsigned i = 0; i < N; i++) begin
            count = count + CNT_W'(busy[i]);
            if (!free_found && !busy[i]) begin
                free_found = 1'b1;
                free_idx   = i[IDX_W-1:0];
            end
            if (!sel_found && busy[i] && rj[i] && rk[i]) begin
                sel_found = 1'b1;
                sel_idx   = i[IDX_W-1:0];
            end
        end
    end

    assign rs_full = (count >= CNT_W'(RS_SIZE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= '0;
            rj        <= '0;
            rk        <= '0;
            alu_valid <= 1'b0;
            alu_op    <= '0;
            alu_Vj    <= '0;
            alu_Vk    <= '0;
            alu_imm   <= '0;
            alu_pc    <= '0;
            alu_RobId <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                op[i]  <= '0;
                vj[i]  <= '0;
                vk[i]  <= '0;
                imm[i] <= '0;
                pc[i]  <= '0;
                qj[i]  <= '0;
                qk[i]  <= '0;
                rob[i] <= '0;
            end
        end else if (rdy) begin
            if (clear) begin
                busy      <= '0;
                alu_valid <= 1'b0;
            end else begin
                for (int unsigned i = 0; i < N; i++) begin
                    if (busy[i]) begin
                        rj[i] <= wake_rj[i];
                        vj[i] <= wake_vj[i];
                        rk[i] <= wake_rk[i];
                        vk[i] <= wake_vk[i];
                    end
                end
                if (sel_found) begin
                    alu_valid     <= 1'b1;
                    alu_op        <= op[sel_idx];
                    alu_Vj        <= vj[sel_idx];
                    alu_Vk        <= vk[sel_idx];
                    alu_imm       <= imm[sel_idx];
                    alu_pc        <= pc[sel_idx];
                    alu_RobId     <= rob[sel_idx];
                    busy[sel_idx] <= 1'b0;
                end else begin
                    alu_valid <= 1'b0;
                end
                if (issue_valid && free_found) begin
                    busy[free_idx] <= 1'b1;
                    op[free_idx]   <= issue_op;
                    vj[free_idx]   <= new_vj;
                    vk[free_idx]   <= new_vk;
                    rj[free_idx]   <= new_rj;
                    rk[free_idx]   <= new_rk;
                    qj[free_idx]   <= issue_Qj;
                    qk[free_idx]   <= issue_Qk;
                    imm[free_idx]  <= issue_imm;
                    pc[free_idx]   <= issue_pc;
                    rob[free_idx]  <= issue_RobId;
                end
            end
        end
    end
endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: expected dispatches are queued at
// issue time and popped by a monitor whenever alu_valid is seen.
module tb_reservation_station;
    logic        clk = 1'b0;
    logic        rst_n, rdy, clear, issue_valid;
    logic [5:0]  issue_op;
    logic [31:0] issue_Vj, issue_Vk, issue_imm, issue_pc;
    logic        issue_Rj, issue_Rk;
    logic [3:0]  issue_Qj, issue_Qk, issue_RobId;
    logic        cdb_alu_valid, cdb_lsb_valid;
    logic [3:0]  cdb_alu_RobId, cdb_lsb_RobId;
    logic [31:0] cdb_alu_value, cdb_lsb_value;
    logic        rs_full, alu_valid;
    logic [5:0]  alu_op;
    logic [31:0] alu_Vj, alu_Vk, alu_imm, alu_pc;
    logic [3:0]  alu_RobId;

    typedef struct packed {
        logic [5:0]  op;
        logic [31:0] vj;
        logic [31:0] vk;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [3:0]  rob;
    } disp_t;

    disp_t sb[$];
    int    n_cmp = 0;
    int    n_err = 0;

    always #5 clk = ~clk;

    reservation_station #(.RS_SIZE(16), .ROB_LOG(4), .OP_LOG(6)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .clear(clear),
        .issue_valid(issue_valid), .issue_op(issue_op),
        .issue_Vj(issue_Vj), .issue_Vk(issue_Vk),
        .issue_Rj(issue_Rj), .issue_Rk(issue_Rk),
        .issue_Qj(issue_Qj), .issue_Qk(issue_Qk),
        .issue_imm(issue_imm), .issue_pc(issue_pc), .issue_RobId(issue_RobId),
        .cdb_alu_valid(cdb_alu_valid), .cdb_alu_RobId(cdb_alu_RobId),
        .cdb_alu_value(cdb_alu_value),
        .cdb_lsb_valid(cdb_lsb_valid), .cdb_lsb_RobId(cdb_lsb_RobId),
        .cdb_lsb_value(cdb_lsb_value),
        .rs_full(rs_full), .alu_valid(alu_valid), .alu_op(alu_op),
        .alu_Vj(alu_Vj), .alu_Vk(alu_Vk), .alu_imm(alu_imm),
        .alu_pc(alu_pc), .alu_RobId(alu_RobId)
    );

    always @(negedge clk) begin
        disp_t got;
        if (rst_n && alu_valid) begin
            got = {alu_op, alu_Vj, alu_Vk, alu_imm, alu_pc, alu_RobId};
            n_cmp++;
            if (sb.size() == 0) begin
                assert (1'b0 === alu_valid) else begin
                    n_err++;
                    $error("FAIL unexpected_dispatch: got pc=%0h rob=%0h required no dispatch",
                           alu_pc, alu_RobId);
                end
            end else begin
                disp_t exp;
                exp = sb.pop_front();
                assert (got === exp) else begin
                    n_err++;
                    $error("FAIL dispatch: got %h required %h", got, exp);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h required %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle();
        issue_valid   = 1'b0;
        cdb_alu_valid = 1'b0;
        cdb_lsb_valid = 1'b0;
        clear         = 1'b0;
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                         input logic r_j, input logic r_k, input logic [3:0] q_j,
                         input logic [3:0] q_k, input logic [31:0] im,
                         input logic [31:0] p, input logic [3:0] rob);
        issue_valid = 1'b1;
        issue_op    = op;
        issue_Vj    = vj;
        issue_Vk    = vk;
        issue_Rj    = r_j;
        issue_Rk    = r_k;
        issue_Qj    = q_j;
        issue_Qk    = q_k;
        issue_imm   = im;
        issue_pc    = p;
        issue_RobId = rob;
    endtask

    task automatic expect_disp(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                               input logic [31:0] im, input logic [31:0] p, input logic [3:0] rob);
        sb.push_back('{op: op, vj: vj, vk: vk, imm: im, pc: p, rob: rob});
    endtask

    task automatic alu_bus(input logic [3:0] id, input logic [31:0] v);
        cdb_alu_valid = 1'b1;
        cdb_alu_RobId = id;
        cdb_alu_value = v;
    endtask

    task automatic lsb_bus(input logic [3:0] id, input logic [31:0] v);
        cdb_lsb_valid = 1'b1;
        cdb_lsb_RobId = id;
        cdb_lsb_value = v;
    endtask

    initial begin
        rst_n = 1'b0;
        rdy   = 1'b1;
        idle();
        issue(6'd0, '0, '0, 1'b0, 1'b0, 4'd0, 4'd0, '0, '0, 4'd0);
        issue_valid = 1'b0;
        cdb_alu_RobId = '0; cdb_alu_value = '0;
        cdb_lsb_RobId = '0; cdb_lsb_value = '0;
        cyc(); cyc();
        chk("reset_alu_valid", alu_valid, 0);
        chk("reset_rs_full", rs_full, 0);
        chk("reset_alu_Vj", alu_Vj, 0);
        chk("reset_alu_RobId", alu_RobId, 0);
        rst_n = 1'b1;
        cyc();

        // Ready ADD: dispatched one edge after issue, strobe lasts one cycle
        issue(6'd1, 32'd5, 32'd7, 1'b1, 1'b1, 4'd0, 4'd0, 32'h11, 32'h100, 4'd3);
        expect_disp(6'd1, 32'd5, 32'd7, 32'h11, 32'h100, 4'd3);
        cyc(); idle();
        chk("add_no_early", alu_valid, 0);
        cyc();
        chk("add_valid", alu_valid, 1);
        chk("add_Vj", alu_Vj, 5);
        chk("add_RobId", alu_RobId, 3);
        cyc();
        chk("add_valid_drop", alu_valid, 0);

        // Wakeup via ALU bus on the third edge after issue
        issue(6'd2, 32'd0, 32'd9, 1'b0, 1'b1, 4'd2, 4'd0, 32'h22, 32'h200, 4'd5);
        expect_disp(6'd2, 32'h10, 32'd9, 32'h22, 32'h200, 4'd5);
        cyc(); idle();
        cyc(); chk("wake_wait1", alu_valid, 0);
        cyc(); chk("wake_wait2", alu_valid, 0);
        alu_bus(4'd2, 32'h10);
        cyc(); idle();
        chk("wake_no_bypass", alu_valid, 0);
        cyc();
        chk("wake_valid", alu_valid, 1);
        chk("wake_Vj", alu_Vj, 32'h10);
        cyc();

        // Dual wake from different buses
        issue(6'd3, 32'd0, 32'd0, 1'b0, 1'b0, 4'd1, 4'd4, 32'h33, 32'h300, 4'd6);
        expect_disp(6'd3, 32'hA, 32'hB, 32'h33, 32'h300, 4'd6);
        cyc(); idle();
        cyc();
        alu_bus(4'd1, 32'hA);
        lsb_bus(4'd4, 32'hB);
        cyc(); idle();
        chk("dual_no_early", alu_valid, 0);
        cyc();
        chk("dual_Vk", alu_Vk, 32'hB);
        cyc();

        // Both operands on one tag, both buses carry it: ALU value wins
        issue(6'd4, 32'd0, 32'd0, 1'b0, 1'b0, 4'd9, 4'd9, 32'h44, 32'h400, 4'd7);
        expect_disp(6'd4, 32'hAA, 32'hAA, 32'h44, 32'h400, 4'd7);
        cyc(); idle();
        alu_bus(4'd9, 32'hAA);
        lsb_bus(4'd9, 32'hBB);
        cyc(); idle();
        cyc();
        chk("prio_Vj", alu_Vj, 32'hAA);
        cyc();

        // Incoming snoop: operand broadcast in the issue cycle
        issue(6'd5, 32'd0, 32'd1, 1'b0, 1'b1, 4'd7, 4'd0, 32'h55, 32'h500, 4'd8);
        lsb_bus(4'd7, 32'h77);
        expect_disp(6'd5, 32'h77, 32'd1, 32'h55, 32'h500, 4'd8);
        cyc(); idle();
        cyc();
        chk("snoop_valid", alu_valid, 1);
        cyc();
        chk("sb_empty_a", sb.size(), 0);

        // Fill: 15 waiting entries raise rs_full; 16th accepted, 17th dropped
        for (int i = 0; i < 15; i++) begin
            issue(6'd6, 32'd0, 32'h200 + i, 1'b0, 1'b1, 4'(i), 4'd0, i, 32'h1000 + i, 4'(i));
            cyc();
            if (i == 13) chk("full_at_14", rs_full, 0);
        end
        chk("full_at_15", rs_full, 1);
        issue(6'd6, 32'd0, 32'h20F, 1'b0, 1'b1, 4'd15, 4'd0, 32'd15, 32'h100F, 4'd15);
        cyc();
        chk("full_at_16", rs_full, 1);
        issue(6'd7, 32'd1, 32'd2, 1'b1, 1'b1, 4'd0, 4'd0, 32'h0, 32'hDEAD, 4'd14);
        cyc(); idle();
        cyc(); cyc();
        chk("drop_no_dispatch", alu_valid, 0);
        alu_bus(4'd5, 32'h55);
        lsb_bus(4'd2, 32'h22);
        expect_disp(6'd6, 32'h22, 32'h202, 32'd2, 32'h1002, 4'd2);
        expect_disp(6'd6, 32'h55, 32'h205, 32'd5, 32'h1005, 4'd5);
        cyc(); idle();
        cyc();
        chk("order_first_pc", alu_pc, 32'h1002);
        chk("order_full_15", rs_full, 1);
        cyc();
        chk("order_second_pc", alu_pc, 32'h1005);
        chk("order_full_14", rs_full, 0);
        cyc();
        chk("order_idle", alu_valid, 0);
        chk("sb_empty_b", sb.size(), 0);
        clear = 1'b1;
        cyc(); idle();
        chk("clear_rs_full", rs_full, 0);

        // Flush: pending entries, a ready one, then issue+broadcasts+clear together
        for (int i = 0; i < 3; i++) begin
            issue(6'd8, 32'd0, 32'd0, 1'b0, 1'b1, 4'(10 + i), 4'd0, 32'd0, 32'h2000 + i, 4'(i));
            cyc();
        end
        issue(6'd8, 32'd1, 32'd1, 1'b1, 1'b1, 4'd0, 4'd0, 32'd0, 32'h2003, 4'd3);
        cyc();
        issue(6'd8, 32'd1, 32'd1, 1'b1, 1'b1, 4'd0, 4'd0, 32'd0, 32'h2004, 4'd4);
        alu_bus(4'd10, 32'h1);
        lsb_bus(4'd11, 32'h2);
        clear = 1'b1;
        cyc(); idle();
        alu_bus(4'd12, 32'h3);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("flush_no_dispatch", alu_valid, 0);
            idle();
        end
        chk("flush_rs_full", rs_full, 0);

        // rdy=0 freezes everything, so a ready issue is ignored
        rdy = 1'b0;
        issue(6'd9, 32'd1, 32'd1, 1'b1, 1'b1, 4'd0, 4'd0, 32'd0, 32'h3000, 4'd1);
        cyc(); cyc(); idle();
        rdy = 1'b1;
        cyc(); cyc();
        chk("rdy_low_dropped", alu_valid, 0);

        // Mid-run async reset while a dispatch is on the outputs
        issue(6'd10, 32'h5A, 32'hA5, 1'b1, 1'b1, 4'd0, 4'd0, 32'h66, 32'h4000, 4'd9);
        expect_disp(6'd10, 32'h5A, 32'hA5, 32'h66, 32'h4000, 4'd9);
        cyc();
        issue(6'd10, 32'd1, 32'd2, 1'b1, 1'b1, 4'd0, 4'd0, 32'h67, 32'h4001, 4'd10);
        cyc(); idle();
        chk("rst_pre_valid", alu_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_valid", alu_valid, 0);
        chk("rst_async_Vj", alu_Vj, 0);
        chk("rst_async_pc", alu_pc, 0);
        chk("rst_async_RobId", alu_RobId, 0);
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rst_no_dispatch", alu_valid, 0);
        end
        chk("rst_rs_full", rs_full, 0);
        chk("sb_empty_end", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
